// File: rtl/pmod_jstk2_multi.sv
// pmod_jstk2_multi
// SPI master for up to NUM_DEV Digilent PmodJSTK2 joysticks on a shared
// sck/mosi/miso bus, with one active-low chip select per device.
// Every transaction is 5 bytes. Bytes received: X lo, X hi, Y lo, Y hi, buttons.
// Bytes sent: 0x84,R,G,B,0x00 when an LED update is pending for the target,
// otherwise five 0x00 bytes.
// Reads start from start_read (manual) or from the auto-poll timer
// (round-robin over devices). The FSM state is held in `state` so checkers
// can bind to it.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start_read        : one-cycle read request for dev_sel (ignored while busy)
//   dev_sel           : target device for start_read / led_we
//   led_we, led_rgb   : store {R,G,B} for dev_sel and mark its LED update pending
//   sck, cs_n, mosi   : SPI mode 0 master outputs
//   miso              : shared slave data
//   x_position, y_position, fs_buttons : per-device results, device d in slice d
//   btn_jstk, btn_trigger              : fs_buttons bits 0 / 1 per device
//   data_valid, valid_dev              : result-update strobe and its device index
//   read_in_progress                   : high whenever the FSM is not IDLE
//
// Handshake: data_valid is a one-cycle strobe with no back-pressure. It is
// high for exactly the cycle in which the valid_dev outputs first show new
// data. The consumer samples the outputs in that cycle or later.
module pmod_jstk2_multi #(
    parameter int NUM_DEV      = 2,
    parameter int SCK_HALF     = 50,
    parameter int CS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1000,
    parameter int CS_HOLD_CYC  = 2500,
    parameter int POLL_CYCLES  = 1000000,
    localparam int DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_read,
    input  logic [DW-1:0]          dev_sel,
    input  logic                   led_we,
    input  logic [23:0]            led_rgb,
    output logic                   sck,
    output logic [NUM_DEV-1:0]     cs_n,
    output logic                   mosi,
    input  logic                   miso,
    output logic [16*NUM_DEV-1:0]  x_position,
    output logic [16*NUM_DEV-1:0]  y_position,
    output logic [8*NUM_DEV-1:0]   fs_buttons,
    output logic [NUM_DEV-1:0]     btn_jstk,
    output logic [NUM_DEV-1:0]     btn_trigger,
    output logic                   data_valid,
    output logic [DW-1:0]          valid_dev,
    output logic                   read_in_progress
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, BYTE_GAP, CS_HOLD} state_t;

    localparam logic [31:0] SETUP_LAST = 32'(CS_SETUP_CYC - 1);
    localparam logic [31:0] HALF_LAST  = 32'(SCK_HALF - 1);
    localparam logic [31:0] BIT_LAST   = 32'(2 * SCK_HALF - 1);
    localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP_CYC - 1);
    // CS_HOLD has one extra leading cycle in which cs_n is still low.
    // cs_n rises at the end of that cycle.
    localparam logic [31:0] HOLD_LAST  = 32'(CS_HOLD_CYC);
    localparam logic [31:0] POLL_LAST  = 32'((POLL_CYCLES > 0) ? POLL_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DEV_LAST = DW'(NUM_DEV - 1);

    state_t                 state;
    logic [31:0]            cnt;
    logic [2:0]             bit_idx;
    logic [2:0]             byte_idx;
    logic [DW-1:0]          tgt;
    logic [7:0]             tx_sh;
    logic [39:0]            rx_sh;
    logic                   use_led;
    logic [23:0]            tx_rgb;
    logic [NUM_DEV-1:0]     led_pend;
    logic [24*NUM_DEV-1:0]  led_store;
    logic [31:0]            poll_cnt;
    logic [DW-1:0]          rr;
    logic                   poll_pend;
    logic [DW-1:0]          poll_dev;

    logic                   manual_ok;
    logic                   led_ok;
    logic                   take_manual;
    logic                   take_poll;
    logic                   accept;
    logic [DW-1:0]          sel;
    logic                   poll_expire;
    logic [7:0]             cur_byte;

    always_comb begin
        manual_ok   = start_read && (int'(dev_sel) < NUM_DEV);
        led_ok      = led_we && (int'(dev_sel) < NUM_DEV);
        // A manual request beats a pending poll. The poll stays pending.
        take_manual = (state == IDLE) && manual_ok;
        take_poll   = (state == IDLE) && !manual_ok && poll_pend;
        accept      = take_manual || take_poll;
        sel         = take_manual ? dev_sel : poll_dev;
        poll_expire = (POLL_CYCLES > 0) && (poll_cnt == POLL_LAST);
        case (byte_idx)
            3'd0:    cur_byte = use_led ? 8'h84 : 8'h00;
            3'd1:    cur_byte = use_led ? tx_rgb[23:16] : 8'h00;
            3'd2:    cur_byte = use_led ? tx_rgb[15:8]  : 8'h00;
            3'd3:    cur_byte = use_led ? tx_rgb[7:0]   : 8'h00;
            default: cur_byte = 8'h00;
        endcase
    end

    for (genvar d = 0; d < NUM_DEV; d++) begin : g_btn
        assign btn_jstk[d]    = fs_buttons[8*d];
        assign btn_trigger[d] = fs_buttons[8*d+1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            byte_idx         <= '0;
            tgt              <= '0;
            tx_sh            <= '0;
            rx_sh            <= '0;
            use_led          <= 1'b0;
            tx_rgb           <= '0;
            led_pend         <= '0;
            led_store        <= '0;
            poll_cnt         <= '0;
            rr               <= '0;
            poll_pend        <= 1'b0;
            poll_dev         <= '0;
            sck              <= 1'b0;
            mosi             <= 1'b0;
            cs_n             <= '1;
            x_position       <= '0;
            y_position       <= '0;
            fs_buttons       <= '0;
            data_valid       <= 1'b0;
            valid_dev        <= '0;
            read_in_progress <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt              <= sel;
                        cs_n             <= ~(NUM_DEV'(1) << sel);
                        use_led          <= led_pend[sel];
                        tx_rgb           <= led_store[24*sel +: 24];
                        byte_idx         <= '0;
                        bit_idx          <= '0;
                        cnt              <= '0;
                        rx_sh            <= '0;
                        read_in_progress <= 1'b1;
                        state            <= CS_SETUP;
                    end
                end
                CS_SETUP, BYTE_GAP: begin
                    if (cnt == ((state == CS_SETUP) ? SETUP_LAST : GAP_LAST)) begin
                        // Load the next byte; the first bit goes out while sck is low.
                        cnt   <= '0;
                        tx_sh <= cur_byte;
                        mosi  <= cur_byte[7];
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        // Rising sck edge: miso was driven on the previous fall.
                        sck   <= 1'b1;
                        rx_sh <= {rx_sh[38:0], miso};
                        cnt   <= cnt + 32'd1;
                    end else if (cnt == BIT_LAST) begin
                        sck <= 1'b0;
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            mosi    <= 1'b0;
                            if (byte_idx == 3'd4) begin
                                state <= CS_HOLD;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                state    <= BYTE_GAP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            mosi    <= tx_sh[6];
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CS_HOLD: begin
                    if (cnt == 32'd0) begin
                        // Deselect and publish all three results together.
                        // Receive order: X lo, X hi, Y lo, Y hi, buttons.
                        cs_n                      <= '1;
                        data_valid                <= 1'b1;
                        valid_dev                 <= tgt;
                        x_position[16*tgt +: 16]  <= {rx_sh[31:24], rx_sh[39:32]};
                        y_position[16*tgt +: 16]  <= {rx_sh[15:8], rx_sh[23:16]};
                        fs_buttons[8*tgt +: 8]    <= rx_sh[7:0];
                        if (use_led) begin
                            led_pend[tgt] <= 1'b0;
                        end
                    end
                    if (cnt == HOLD_LAST) begin
                        cnt              <= '0;
                        read_in_progress <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so that a same-cycle LED write wins over the clear.
            if (led_ok) begin
                led_pend[dev_sel]            <= 1'b1;
                led_store[24*dev_sel +: 24]  <= led_rgb;
            end

            if (POLL_CYCLES > 0) begin
                poll_cnt <= poll_expire ? 32'd0 : poll_cnt + 32'd1;
            end
            if (take_poll) begin
                poll_pend <= 1'b0;
            end
            // Only one poll can be pending. An expiry that finds one already
            // pending is dropped and does not advance the round-robin pointer.
            if (poll_expire && (!poll_pend || take_poll)) begin
                poll_pend <= 1'b1;
                poll_dev  <= rr;
                rr        <= (rr == DEV_LAST) ? '0 : rr + 1'b1;
            end
        end
    end

endmodule

// File: doc/pmod_jstk2_multi.md
PMOD_JSTK2_MULTI -- requirements
Module: pmod_jstk2_multi

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_DEV, 2: number of JSTK2 slaves sharing sck/mosi/miso.
- SCK_HALF, 50: clk cycles per sck half-period.
- CS_SETUP_CYC, 1500: clk cycles from cs_n fall to first sck rise.
- BYTE_GAP_CYC, 1000: sck-low clk cycles between bytes.
- CS_HOLD_CYC, 2500: idle cycles after cs_n rise before the next transaction.
- POLL_CYCLES, 1000000: auto-poll period in clk cycles; 0 disables auto-poll.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning); DW = max(1, clog2(NUM_DEV)):
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- start_read, in, 1: one-cycle manual read request.
- dev_sel, in, DW: target device for start_read and led_we.
- led_we, in, 1: latch led_rgb for dev_sel.
- led_rgb, in, 24: {R,G,B}.
- sck, out, 1: SPI clock, mode 0, idle low.
- cs_n, out, NUM_DEV: per-device active-low select.
- mosi, out, 1: master data.
- miso, in, 1: shared slave data.
- x_position, out, 16*NUM_DEV: device d at [16d+15:16d].
- y_position, out, 16*NUM_DEV: device d at [16d+15:16d].
- fs_buttons, out, 8*NUM_DEV: device d at [8d+7:8d].
- btn_jstk, out, NUM_DEV: fs_buttons bit 0 per device.
- btn_trigger, out, NUM_DEV: fs_buttons bit 1 per device.
- data_valid, out, 1: one-cycle pulse when a device's outputs update.
- valid_dev, out, DW: device index qualifying data_valid.
- read_in_progress, out, 1: high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, CS_SETUP, SHIFT, BYTE_GAP, CS_HOLD.
REQ-004 IDLE → CS_SETUP on an accepted request; the target's cs_n SHALL go low on the next clk edge; all other cs_n bits SHALL stay high.
REQ-005 CS_SETUP SHALL last CS_SETUP_CYC cycles; then SHIFT.
REQ-006 SHIFT SHALL produce 8 sck periods per byte, each SCK_HALF cycles low then SCK_HALF cycles high, MSB first.
REQ-007 mosi SHALL change only while sck is low; miso SHALL be sampled on the clk cycle in which sck rises.
REQ-008 After bytes 0-3, the FSM SHALL go to BYTE_GAP (BYTE_GAP_CYC cycles, sck low), then back to SHIFT.
REQ-009 After byte 4, cs_n SHALL rise on the cycle after the last sck fall, followed by CS_HOLD for CS_HOLD_CYC cycles, then IDLE.
REQ-010 A transaction is always 5 bytes; received byte order SHALL be X[7:0], X[15:8], Y[7:0], Y[15:8], buttons.
REQ-011 On the cs_n-rise cycle, the target device's x, y and fs_buttons SHALL update together, data_valid SHALL pulse for exactly 1 cycle, and valid_dev SHALL equal the target index.
REQ-012 Other devices' outputs SHALL be unchanged by the transaction.
REQ-013 led_we SHALL set a per-device LED-pending flag and store led_rgb; a later led_we before use SHALL overwrite the stored value.
REQ-014 When the target's LED-pending flag is set, mosi bytes SHALL be 0x84, R, G, B, 0x00 and the flag SHALL clear at cs_n rise; otherwise all 5 mosi bytes SHALL be 0x00.
REQ-015 Auto-poll (POLL_CYCLES>0): a free-running counter SHALL raise a poll request every POLL_CYCLES cycles, targeting devices round-robin 0,1,…,NUM_DEV-1,0.
REQ-016 A poll request SHALL be held pending until IDLE; at most one SHALL be pending, and extra expiries are dropped.
REQ-017 If start_read and a pending poll are both present in IDLE, start_read SHALL win and the poll SHALL stay pending.
REQ-018 start_read while read_in_progress=1, or with dev_sel >= NUM_DEV, SHALL be ignored without error indication; led_we with dev_sel >= NUM_DEV SHALL be ignored.
REQ-019 Transaction length, request to IDLE, SHALL be exactly 1 + CS_SETUP_CYC + 80*SCK_HALF + 4*BYTE_GAP_CYC + 1 + CS_HOLD_CYC cycles.

Reset
REQ-020 Reset SHALL asynchronously force: state IDLE; sck=0; mosi=0; cs_n all 1; all position/button outputs 0; data_valid=0; valid_dev=0; read_in_progress=0; LED-pending flags and stored RGB cleared; poll counter, round-robin pointer and pending poll cleared.
REQ-021 Reset during any transaction SHALL discard the partial shift data; outputs remain 0 after release.

Verification
Bench settings: NUM_DEV=2, SCK_HALF=2, CS_SETUP_CYC=4, BYTE_GAP_CYC=3, CS_HOLD_CYC=5, POLL_CYCLES=0 unless stated; the slave model drives miso on sck fall.
REQ-022 start_read dev_sel=0 with slave bytes FF,FF,00,00,03 → x[15:0]=FFFF, y=0000, fs=03, btn_jstk[0]=btn_trigger[0]=1, valid_dev=0, device 1 outputs unchanged, data_valid a single-cycle pulse.
REQ-023 start_read dev_sel=1 with bytes 00,80,00,80,00 → x[31:16]=8000, y[31:16]=8000, only cs_n[1] low, total 1+4+160+12+1+5=183 cycles.
REQ-024 led_we dev_sel=0 with led_rgb=123456, then read dev 0 → mosi bytes 84,12,34,56,00; an immediate second read → mosi all 00.
REQ-025 POLL_CYCLES=400 → reads alternate dev 0, 1, 0; start_read coincident with a poll expiry is served first and the poll follows.
REQ-026 Assert reset mid-byte 2 → cs_n=11, sck=0 immediately, outputs 0; a fresh read after release completes correctly.
